// File: rtl/alarm_ctrl.sv
// Alarm state machine: compares decoded time against a stored alarm and drives ring/beep/snooze outputs.
// Optional ring auto-stop is compiled in with `define ALARM_CTRL_AUTO_STOP_EN.
module alarm_ctrl #(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned MAX_SNOOZE       = 3,
    parameter int unsigned RING_TIMEOUT_SEC = 600,
    parameter int unsigned ALARM_HOUR_RST   = 7,
    parameter int unsigned ALARM_MIN_RST    = 0,
    localparam int unsigned SL_W = $clog2(SNOOZE_SEC + 1)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [4:0]      hour_i,
    input  logic [5:0]      min_i,
    input  logic [5:0]      sec_i,
    input  logic            last_tick_i,
    input  logic [4:0]      alarm_hour_i,
    input  logic [5:0]      alarm_min_i,
    input  logic            alarm_set_en_i,
    input  logic            arm_toggle_i,
    input  logic            stop_i,
    input  logic            snooze_i,
    output logic [4:0]      alarm_hour_o,
    output logic [5:0]      alarm_min_o,
    output logic            armed_o,
    output logic            ringing_o,
    output logic            snoozed_o,
    output logic            beep_o,
    output logic [SL_W-1:0] snooze_left_o
);

    localparam int unsigned SU_W = $clog2(MAX_SNOOZE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_RING   = 2'd2;
    localparam logic [1:0] S_SNOOZE = 2'd3;

    if (SNOOZE_SEC < 1 || MAX_SNOOZE < 1 || RING_TIMEOUT_SEC < 1 ||
        ALARM_HOUR_RST > 23 || ALARM_MIN_RST > 59) begin : g_param_chk
        $error("alarm_ctrl: parameter out of range");
    end

    logic [1:0]      state_q, state_d;
    logic [4:0]      alarm_hour_q;
    logic [5:0]      alarm_min_q;
    logic            match_q, match, trigger;
    logic            beep_q, beep_d;
    logic [SL_W-1:0] snooze_left_q, snooze_left_d;
    logic [SU_W-1:0] snooze_used_q, snooze_used_d;
`ifdef ALARM_CTRL_AUTO_STOP_EN
    localparam int unsigned RC_W = $clog2(RING_TIMEOUT_SEC + 1);
    logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;
`endif

    // Edge-detect the match so one alarm second fires at most once.
    assign match   = (hour_i == alarm_hour_q) && (min_i == alarm_min_q) && (sec_i == 6'd0);
    assign trigger = match && !match_q;

    always_comb begin
        state_d       = state_q;
        beep_d        = beep_q;
        snooze_left_d = snooze_left_q;
        snooze_used_d = snooze_used_q;
`ifdef ALARM_CTRL_AUTO_STOP_EN
        ring_cnt_d    = ring_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm_toggle_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (arm_toggle_i) begin
                    state_d = S_IDLE;
                end else if (trigger) begin
                    state_d       = S_RING;
                    snooze_used_d = '0;
                    beep_d        = 1'b1;
`ifdef ALARM_CTRL_AUTO_STOP_EN
                    ring_cnt_d    = '0;
`endif
                end
            end
            S_RING: begin
                if (arm_toggle_i) begin
                    state_d = S_IDLE;
                end else if (stop_i) begin
                    state_d = S_ARMED;
                end else if (snooze_i) begin
                    if (snooze_used_q < SU_W'(MAX_SNOOZE)) begin
                        state_d       = S_SNOOZE;
                        snooze_left_d = SL_W'(SNOOZE_SEC);
                        snooze_used_d = snooze_used_q + SU_W'(1);
                    end else begin
                        state_d = S_ARMED;
                    end
                end else if (last_tick_i) begin
                    beep_d = ~beep_q;
`ifdef ALARM_CTRL_AUTO_STOP_EN
                    if (ring_cnt_q == RC_W'(RING_TIMEOUT_SEC - 1)) begin
                        state_d    = S_ARMED;
                        ring_cnt_d = '0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RC_W'(1);
                    end
`endif
                end
            end
            S_SNOOZE: begin
                if (arm_toggle_i) begin
                    state_d = S_IDLE;
                end else if (stop_i) begin
                    state_d = S_ARMED;
                end else if (last_tick_i) begin
                    if (snooze_left_q == SL_W'(1)) begin
                        state_d    = S_RING;
                        beep_d     = 1'b1;
`ifdef ALARM_CTRL_AUTO_STOP_EN
                        ring_cnt_d = '0;
`endif
                    end else if (snooze_left_q != '0) begin
                        snooze_left_d = snooze_left_q - SL_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Gate outputs by the next state so every exit path clears them.
        if (state_d != S_RING)   beep_d        = 1'b0;
        if (state_d != S_SNOOZE) snooze_left_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            alarm_hour_q  <= 5'(ALARM_HOUR_RST);
            alarm_min_q   <= 6'(ALARM_MIN_RST);
            match_q       <= 1'b0;
            beep_q        <= 1'b0;
            snooze_left_q <= '0;
            snooze_used_q <= '0;
`ifdef ALARM_CTRL_AUTO_STOP_EN
            ring_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            match_q       <= match;
            beep_q        <= beep_d;
            snooze_left_q <= snooze_left_d;
            snooze_used_q <= snooze_used_d;
`ifdef ALARM_CTRL_AUTO_STOP_EN
            ring_cnt_q    <= ring_cnt_d;
`endif
            // An out-of-range field rejects the whole load.
            if (alarm_set_en_i && alarm_hour_i <= 5'd23 && alarm_min_i <= 6'd59) begin
                alarm_hour_q <= alarm_hour_i;
                alarm_min_q  <= alarm_min_i;
            end
        end
    end

    assign alarm_hour_o  = alarm_hour_q;
    assign alarm_min_o   = alarm_min_q;
    assign armed_o       = (state_q != S_IDLE);
    assign ringing_o     = (state_q == S_RING);
    assign snoozed_o     = (state_q == S_SNOOZE);
    assign beep_o        = beep_q;
    assign snooze_left_o = snooze_left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus pushes expected output snapshots, a negedge monitor compares.
module tb_alarm_ctrl;

    localparam int unsigned SL_W = $clog2(300 + 1);

    typedef struct packed {
        logic [4:0]      ah;
        logic [5:0]      am;
        logic            armed;
        logic            ring;
        logic            snz;
        logic            beep;
        logic [SL_W-1:0] sl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] hour, ah_in;
    logic [5:0] min, sec, am_in;
    logic last_tick, set_en, arm, stop, snooze;
    logic [4:0] ah_o;
    logic [5:0] am_o;
    logic armed_o, ringing_o, snoozed_o, beep_o;
    logic [SL_W-1:0] sl_o;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .SNOOZE_SEC(300), .MAX_SNOOZE(3), .RING_TIMEOUT_SEC(4),
        .ALARM_HOUR_RST(7), .ALARM_MIN_RST(0)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .hour_i(hour), .min_i(min), .sec_i(sec), .last_tick_i(last_tick),
        .alarm_hour_i(ah_in), .alarm_min_i(am_in), .alarm_set_en_i(set_en),
        .arm_toggle_i(arm), .stop_i(stop), .snooze_i(snooze),
        .alarm_hour_o(ah_o), .alarm_min_o(am_o),
        .armed_o(armed_o), .ringing_o(ringing_o), .snoozed_o(snoozed_o),
        .beep_o(beep_o), .snooze_left_o(sl_o)
    );

    // Monitor: one expectation per cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = '{ah: ah_o, am: am_o, armed: armed_o, ring: ringing_o,
                  snz: snoozed_o, beep: beep_o, sl: sl_o};
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s: got hh=%0d mm=%0d arm=%b ring=%b snz=%b beep=%b left=%0d, want hh=%0d mm=%0d arm=%b ring=%b snz=%b beep=%b left=%0d",
                         n, g.ah, g.am, g.armed, g.ring, g.snz, g.beep, g.sl,
                         e.ah, e.am, e.armed, e.ring, e.snz, e.beep, e.sl);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        arm = 1'b0; stop = 1'b0; snooze = 1'b0; set_en = 1'b0; last_tick = 1'b0;
    endtask

    task automatic tick();
        last_tick = 1'b1;
        step();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour = 5'(h); min = 6'(m); sec = 6'(s);
    endtask

    task automatic chk(input string n, input int ah, input int am, input int a,
                       input int r, input int z, input int b, input int sl);
        exp_t e;
        e = '{ah: 5'(ah), am: 6'(am), armed: a[0], ring: r[0], snz: z[0], beep: b[0], sl: SL_W'(sl)};
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic ring_at(input int h, input int m, input string n);
        set_time((m == 0) ? h - 1 : h, (m == 0) ? 59 : m - 1, 59);
        step();
        set_time(h, m, 0);
        step();
        chk(n, ah_o, am_o, 1, 1, 0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ah_in = '0; am_in = '0;
        last_tick = 0; set_en = 0; arm = 0; stop = 0; snooze = 0;
        set_time(0, 0, 1);
        step(); step();
        chk("reset", 7, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;

        ah_in = 8;  am_in = 30; set_en = 1; step(); chk("load_valid",   8, 30, 0, 0, 0, 0, 0);
        ah_in = 24; am_in = 61; set_en = 1; step(); chk("load_invalid", 8, 30, 0, 0, 0, 0, 0);
        ah_in = 7;  am_in = 0;  set_en = 1; step(); chk("load_0700",    7, 0,  0, 0, 0, 0, 0);

        set_time(6, 59, 59); arm = 1; step(); chk("arm", 7, 0, 1, 0, 0, 0, 0);
        set_time(7, 0, 0); last_tick = 1; step(); chk("trigger", 7, 0, 1, 1, 0, 1, 0);
        set_time(7, 0, 1); last_tick = 1; step(); chk("beep_off", 7, 0, 1, 1, 0, 0, 0);
        set_time(7, 0, 2); last_tick = 1; step(); chk("beep_on",  7, 0, 1, 1, 0, 1, 0);

        for (int k = 0; k < 3; k++) begin
            snooze = 1; step(); chk("snooze_enter", 7, 0, 1, 0, 1, 0, 300);
            tick();             chk("snooze_tick",  7, 0, 1, 0, 1, 0, 299);
            repeat (298) tick();
            chk("snooze_last", 7, 0, 1, 0, 1, 0, 1);
            tick();             chk("re_ring",      7, 0, 1, 1, 0, 1, 0);
        end
        snooze = 1; step(); chk("snooze_limit", 7, 0, 1, 0, 0, 0, 0);

        ring_at(7, 0, "ring_stop");
        stop = 1; snooze = 1; step(); chk("stop_over_snooze", 7, 0, 1, 0, 0, 0, 0);
        step(); step(); step();
        chk("no_retrigger", 7, 0, 1, 0, 0, 0, 0);

        ring_at(7, 0, "ring_snz_stop");
        snooze = 1; step(); chk("snooze_again", 7, 0, 1, 0, 1, 0, 300);
        tick();             chk("snooze_again_tick", 7, 0, 1, 0, 1, 0, 299);
        stop = 1; step();   chk("stop_from_snooze", 7, 0, 1, 0, 0, 0, 0);

        ring_at(7, 0, "ring_arm");
        arm = 1; stop = 1; step(); chk("arm_over_stop", 7, 0, 0, 0, 0, 0, 0);

        set_time(6, 59, 59); step();
        set_time(7, 0, 0); arm = 1; step(); chk("arm_at_match", 7, 0, 1, 0, 0, 0, 0);
        step();                             chk("arm_at_match_hold", 7, 0, 1, 0, 0, 0, 0);
        set_time(7, 0, 1); step();
        ring_at(7, 0, "next_day");

        ah_in = 9; am_in = 15; set_en = 1; step(); chk("load_in_ring", 9, 15, 1, 1, 0, 1, 0);
`ifdef ALARM_CTRL_AUTO_STOP_EN
        repeat (3) tick(); chk("pre_timeout", 9, 15, 1, 1, 0, 0, 0);
        tick();            chk("timeout",     9, 15, 1, 0, 0, 0, 0);
`else
        repeat (10) tick(); chk("no_timeout", 9, 15, 1, 1, 0, 1, 0);
`endif
        stop = 1; step();
        ring_at(9, 15, "ring_9_15");
        step();
        rst_n = 1'b0;
        chk("reset_mid_ring", 7, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", 7, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
